// File: rtl/hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_controller_pkg
//   Shared definitions for the RV32i pipeline hazard controller:
//   result-select encodings, controller FSM states and forwarding selects.
// ---------------------------------------------------------------------------
package hazard_controller_pkg;

   // Result_Src_Sel encodings of the Execute stage (RESULT_MEM marks a load)
   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } hazard_state_t;

   // EX-stage operand forwarding selects
   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_W    = 2'b01;
   localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/hazard_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_controller_if
//   Bundle of the pipeline-side signals seen by the hazard controller.
//   master : pipeline datapath (drives register ids / hazard status,
//            receives stall, flush, forward, fault and counters)
//   slave  : hazard controller
// ---------------------------------------------------------------------------
interface hazard_controller_if;

   // Decode / Execute / Memory / Writeback status
   logic [4:0]  RS1_D;
   logic [4:0]  RS2_D;
   logic [4:0]  RS1_E;
   logic [4:0]  RS2_E;
   logic [4:0]  RD_E;
   logic [1:0]  Result_Src_Sel_E;
   logic        Mispredict_E;
   logic [4:0]  RD_M;
   logic [4:0]  RD_W;
   logic        REG_W_En_M;
   logic        REG_W_En_W;
   logic        MEM_Req_M;
   logic        MEM_Ack;

   // Controller outputs
   logic        Stall_F;
   logic        Stall_D;
   logic        Stall_E;
   logic        Stall_M;
   logic        Flush_D;
   logic        Flush_E;
   logic        Flush_W;
   logic [1:0]  Forward_A_E;
   logic [1:0]  Forward_B_E;
   logic        Mem_Fault;
   logic [31:0] Stall_Count;
   logic [31:0] Flush_Count;

   modport master (
      output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, Result_Src_Sel_E, Mispredict_E,
             RD_M, RD_W, REG_W_En_M, REG_W_En_W, MEM_Req_M, MEM_Ack,
      input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
             Forward_A_E, Forward_B_E, Mem_Fault, Stall_Count, Flush_Count
   );

   modport slave (
      input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, Result_Src_Sel_E, Mispredict_E,
             RD_M, RD_W, REG_W_En_M, REG_W_En_W, MEM_Req_M, MEM_Ack,
      output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
             Forward_A_E, Forward_B_E, Mem_Fault, Stall_Count, Flush_Count
   );

endinterface

// File: rtl/hazard_controller_forwarding_unit.sv
// ---------------------------------------------------------------------------
// hazard_controller_forwarding_unit
//   Combinational forwarding select for one EX-stage source operand.
//   rs_e        : source register of the operand in Execute
//   rd_m, rd_w  : destinations in Memory / Writeback
//   reg_w_en_m/w: write enables in Memory / Writeback
//   fwd_sel     : FWD_M, FWD_W or FWD_NONE (Memory has priority)
// ---------------------------------------------------------------------------
module hazard_controller_forwarding_unit
   import hazard_controller_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_w_en_m,
   input  logic       reg_w_en_w,
   output logic [1:0] fwd_sel
);

   // x0 is hard-wired to zero and is never forwarded
   always_comb begin
      fwd_sel = FWD_NONE;
      if (reg_w_en_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
         fwd_sel = FWD_M;
      end else if (reg_w_en_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
         fwd_sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//   Pipeline sequencing controller for the five-stage RV32i core.
//   - post-reset NOP fill (INIT_CYCLES cycles of flush)
//   - load-use stall and branch-mispredict flush
//   - wait / timeout handshake with multi-cycle data memory
//   - EX-stage operand forwarding selects
//   - saturating stall / flush performance counters
//   Ports:
//     CLK : clock, rising edge
//     RST : synchronous active-high reset
//     hz  : hazard_controller_if.slave (all pipeline-side signals)
// ---------------------------------------------------------------------------
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int INIT_CYCLES = 3,   // 1..15
   parameter int MEM_TIMEOUT = 64   // 2..255
) (
   input  logic                CLK,
   input  logic                RST,
   hazard_controller_if.slave  hz
);

   localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   hazard_state_t state, state_nxt;
   logic [3:0]    init_cnt, init_cnt_nxt;
   logic [7:0]    wait_cnt, wait_cnt_nxt;
   logic          fault_nxt;
   logic          mem_fault;
   logic [31:0]   stall_count, flush_count;

   logic          stall_f, stall_d, stall_e, stall_m;
   logic          flush_d, flush_e, flush_w;
   logic          load_use;

   assign load_use = (hz.Result_Src_Sel_E == RESULT_MEM) && (hz.RD_E != 5'd0) &&
                     ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));

   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      wait_cnt_nxt = wait_cnt;
      fault_nxt    = 1'b0;
      stall_f      = 1'b0;
      stall_d      = 1'b0;
      stall_e      = 1'b0;
      stall_m      = 1'b0;
      flush_d      = 1'b0;
      flush_e      = 1'b0;
      flush_w      = 1'b0;
      case (state)
         INIT: begin
            stall_f      = 1'b1;
            flush_d      = 1'b1;
            flush_e      = 1'b1;
            flush_w      = 1'b1;
            init_cnt_nxt = init_cnt + 4'd1;
            if (init_cnt == INIT_LAST) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (hz.MEM_Req_M && !hz.MEM_Ack) begin
               stall_f      = 1'b1;
               stall_d      = 1'b1;
               stall_e      = 1'b1;
               stall_m      = 1'b1;
               flush_w      = 1'b1;
               wait_cnt_nxt = 8'd1;
               state_nxt    = MEM_WAIT;
            end else if (hz.Mispredict_E) begin
               // the load-use dependent instruction is squashed anyway
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
         MEM_WAIT: begin
            // Hazards upstream are frozen by the stalls and resolved back in RUN
            if (hz.MEM_Ack) begin
               state_nxt = RUN;
            end else begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
               flush_w = 1'b1;
               if (wait_cnt == WAIT_LAST) begin
                  fault_nxt = 1'b1;
                  state_nxt = RUN;
               end else begin
                  wait_cnt_nxt = wait_cnt + 8'd1;
               end
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= INIT;
         init_cnt    <= 4'd0;
         wait_cnt    <= 8'd0;
         mem_fault   <= 1'b0;
         stall_count <= 32'd0;
         flush_count <= 32'd0;
      end else begin
         state     <= state_nxt;
         init_cnt  <= init_cnt_nxt;
         wait_cnt  <= wait_cnt_nxt;
         mem_fault <= fault_nxt;
         // INIT-phase stalls are fill, not hazards, so they are not counted
         if (stall_f && (state != INIT)) begin
            stall_count <= sat_inc(stall_count);
         end
         if ((state == RUN) && hz.Mispredict_E) begin
            flush_count <= sat_inc(flush_count);
         end
      end
   end

   assign hz.Stall_F     = stall_f;
   assign hz.Stall_D     = stall_d;
   assign hz.Stall_E     = stall_e;
   assign hz.Stall_M     = stall_m;
   assign hz.Flush_D     = flush_d;
   assign hz.Flush_E     = flush_e;
   assign hz.Flush_W     = flush_w;
   assign hz.Mem_Fault   = mem_fault;
   assign hz.Stall_Count = stall_count;
   assign hz.Flush_Count = flush_count;

   hazard_controller_forwarding_unit u_fwd_a (
      .rs_e       (hz.RS1_E),
      .rd_m       (hz.RD_M),
      .rd_w       (hz.RD_W),
      .reg_w_en_m (hz.REG_W_En_M),
      .reg_w_en_w (hz.REG_W_En_W),
      .fwd_sel    (hz.Forward_A_E)
   );

   hazard_controller_forwarding_unit u_fwd_b (
      .rs_e       (hz.RS2_E),
      .rd_m       (hz.RD_M),
      .rd_w       (hz.RD_W),
      .reg_w_en_m (hz.REG_W_En_M),
      .reg_w_en_w (hz.REG_W_En_W),
      .fwd_sel    (hz.Forward_B_E)
   );

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//   Directed test of hazard_controller with INIT_CYCLES=3, MEM_TIMEOUT=8.
//   Control outputs are compared as {Stall_F,Stall_D,Stall_E,Stall_M,
//   Flush_D,Flush_E,Flush_W}.
// ---------------------------------------------------------------------------
module tb_hazard_controller;
   import hazard_controller_pkg::*;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   hazard_controller_if hz();

   hazard_controller #(.INIT_CYCLES(3), .MEM_TIMEOUT(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .hz  (hz)
   );

   localparam logic [6:0] CTL_IDLE = 7'b0000_000;
   localparam logic [6:0] CTL_INIT = 7'b1000_111;
   localparam logic [6:0] CTL_LU   = 7'b1100_010;
   localparam logic [6:0] CTL_MP   = 7'b0000_110;
   localparam logic [6:0] CTL_MW   = 7'b1111_001;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ctl();
      return 32'({hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Stall_M,
                  hz.Flush_D, hz.Flush_E, hz.Flush_W});
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr_inputs();
      hz.RS1_D = 5'd0; hz.RS2_D = 5'd0; hz.RS1_E = 5'd0; hz.RS2_E = 5'd0;
      hz.RD_E = 5'd0; hz.Result_Src_Sel_E = RESULT_ALU; hz.Mispredict_E = 1'b0;
      hz.RD_M = 5'd0; hz.RD_W = 5'd0; hz.REG_W_En_M = 1'b0; hz.REG_W_En_W = 1'b0;
      hz.MEM_Req_M = 1'b0; hz.MEM_Ack = 1'b0;
   endtask

   initial begin
      clr_inputs();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      // reset state / NOP fill
      chk("rst_fault", 32'(hz.Mem_Fault), 32'd0);
      chk("rst_stall_cnt", hz.Stall_Count, 32'd0);
      chk("rst_flush_cnt", hz.Flush_Count, 32'd0);
      chk("rst_fwd", 32'({hz.Forward_A_E, hz.Forward_B_E}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("init_fill%0d", i), ctl(), 32'(CTL_INIT));
         tick();
      end
      chk("init_done", ctl(), 32'(CTL_IDLE));
      chk("init_no_count", hz.Stall_Count, 32'd0);

      // load-use on RS1
      hz.Result_Src_Sel_E = RESULT_MEM; hz.RD_E = 5'd5; hz.RS1_D = 5'd5;
      #1 chk("lu_rs1", ctl(), 32'(CTL_LU));
      tick();
      clr_inputs();
      #1 chk("lu_one_bubble", ctl(), 32'(CTL_IDLE));
      chk("lu_stall_cnt", hz.Stall_Count, 32'd1);

      // load to x0 is not a hazard
      hz.Result_Src_Sel_E = RESULT_MEM; hz.RD_E = 5'd0; hz.RS1_D = 5'd0;
      #1 chk("lu_x0", ctl(), 32'(CTL_IDLE));
      // ALU result is not a load
      hz.Result_Src_Sel_E = RESULT_ALU; hz.RD_E = 5'd9; hz.RS2_D = 5'd9;
      #1 chk("lu_alu", ctl(), 32'(CTL_IDLE));
      // load-use on RS2
      hz.Result_Src_Sel_E = RESULT_MEM;
      #1 chk("lu_rs2", ctl(), 32'(CTL_LU));
      tick();
      clr_inputs();
      #1 chk("lu2_stall_cnt", hz.Stall_Count, 32'd2);

      // mispredict over load-use
      hz.Result_Src_Sel_E = RESULT_MEM; hz.RD_E = 5'd5; hz.RS1_D = 5'd5;
      hz.Mispredict_E = 1'b1;
      #1 chk("mp_over_lu", ctl(), 32'(CTL_MP));
      tick();
      clr_inputs();
      #1 chk("mp_flush_cnt", hz.Flush_Count, 32'd1);
      chk("mp_stall_cnt", hz.Stall_Count, 32'd2);

      // memory wait: 4 stalled cycles then ack; mispredict ignored in MEM_WAIT
      hz.MEM_Req_M = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) hz.Mispredict_E = 1'b1;
         #1 chk($sformatf("mw_stall%0d", i), ctl(), 32'(CTL_MW));
         tick();
      end
      hz.MEM_Ack = 1'b1; hz.Mispredict_E = 1'b0;
      #1 chk("mw_ack", ctl(), 32'(CTL_IDLE));
      tick();
      clr_inputs();
      #1 chk("mw_after", ctl(), 32'(CTL_IDLE));
      chk("mw_stall_cnt", hz.Stall_Count, 32'd6);
      chk("mw_flush_cnt", hz.Flush_Count, 32'd1);
      chk("mw_no_fault", 32'(hz.Mem_Fault), 32'd0);

      // timeout after 8 stalled cycles
      hz.MEM_Req_M = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1 chk($sformatf("to_stall%0d", i), ctl(), 32'(CTL_MW));
         chk($sformatf("to_nofault%0d", i), 32'(hz.Mem_Fault), 32'd0);
         tick();
      end
      hz.MEM_Req_M = 1'b0;
      #1 chk("to_fault", 32'(hz.Mem_Fault), 32'd1);
      chk("to_run", ctl(), 32'(CTL_IDLE));
      tick();
      chk("to_pulse_end", 32'(hz.Mem_Fault), 32'd0);
      chk("to_stall_cnt", hz.Stall_Count, 32'd14);

      // reset on the would-be timeout cycle suppresses the fault
      hz.MEM_Req_M = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      #1 chk("rw_stalled", ctl(), 32'(CTL_MW));
      RST = 1'b1;
      tick();
      RST = 1'b0;
      hz.MEM_Req_M = 1'b0;
      #1 chk("rw_no_fault", 32'(hz.Mem_Fault), 32'd0);
      chk("rw_init", ctl(), 32'(CTL_INIT));
      chk("rw_cnt_clr", hz.Stall_Count, 32'd0);
      for (int i = 0; i < 3; i++) tick();
      chk("rw_run", ctl(), 32'(CTL_IDLE));

      // ack together with mispredict: mispredict flush, no wait
      hz.MEM_Req_M = 1'b1; hz.MEM_Ack = 1'b1; hz.Mispredict_E = 1'b1;
      #1 chk("ack_mp", ctl(), 32'(CTL_MP));
      tick();
      clr_inputs();
      #1 chk("ack_mp_run", ctl(), 32'(CTL_IDLE));
      chk("ack_mp_flush_cnt", hz.Flush_Count, 32'd1);

      // forwarding
      hz.RD_M = 5'd7; hz.RD_W = 5'd7; hz.REG_W_En_M = 1'b1; hz.REG_W_En_W = 1'b1;
      hz.RS1_E = 5'd7; hz.RS2_E = 5'd0;
      #1 chk("fwd_a_m", 32'(hz.Forward_A_E), 32'(2'b10));
      chk("fwd_b_x0", 32'(hz.Forward_B_E), 32'(2'b00));
      hz.REG_W_En_M = 1'b0;
      #1 chk("fwd_a_w", 32'(hz.Forward_A_E), 32'(2'b01));
      hz.RD_M = 5'd3; hz.REG_W_En_M = 1'b1; hz.RD_W = 5'd4; hz.RS1_E = 5'd4; hz.RS2_E = 5'd3;
      #1 chk("fwd_a_w2", 32'(hz.Forward_A_E), 32'(2'b01));
      chk("fwd_b_m", 32'(hz.Forward_B_E), 32'(2'b10));
      hz.REG_W_En_W = 1'b0;
      #1 chk("fwd_a_none", 32'(hz.Forward_A_E), 32'(2'b00));
      clr_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage RV32i core. Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding selects. It does three jobs: a post-reset NOP-fill sequence, load-use and branch-mispredict hazard resolution, and a wait/timeout handshake with multi-cycle data memory. It also keeps saturating stall/flush performance counters.

## Interface
- INIT_CYCLES, 3: cycles of forced flush after reset; legal range 1–15.
- MEM_TIMEOUT, 64: max wait cycles for MEM_Ack before fault; legal range 2–255.
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- RS1_D, RS2_D  in  5  source registers of the instruction in Decode.
- RS1_E, RS2_E, RD_E  in  5  source and destination registers in Execute.
- Result_Src_Sel_E  in  2  result select in Execute; RESULT_MEM means a load.
- Mispredict_E  in  1  branch/jump resolved wrong in Execute.
- RD_M, RD_W  in  5  destinations in Memory and Writeback.
- REG_W_En_M, REG_W_En_W  in  1  write enables in Memory and Writeback.
- MEM_Req_M  in  1  data-memory access issued by the instruction in Memory.
- MEM_Ack  in  1  data memory has completed the access this cycle.
- Stall_F, Stall_D, Stall_E, Stall_M  out  1  hold the PC and the IF/ID, ID/EX, EX/MEM registers.
- Flush_D, Flush_E, Flush_W  out  1  load NOPs into IF/ID, ID/EX, MEM/WB.
- Forward_A_E, Forward_B_E  out  2  operand forwarding selects.
- Mem_Fault  out  1  one-cycle pulse on memory timeout.
- Stall_Count, Flush_Count  out  32  saturating performance counters.

## Operation
- FSM states: INIT, RUN, MEM_WAIT.
- RST forces the state to INIT and zeroes init_cnt, wait_cnt, both counters and Mem_Fault.
- **INIT:**
  - Stall_F=1, Flush_D=1, Flush_E=1, Flush_W=1; all other stalls 0.
  - init_cnt increments each cycle; move to RUN after INIT_CYCLES cycles.
  - Hazard inputs are ignored.
- **RUN, priorities highest first:**
  1. Memory wait. Condition: MEM_Req_M && !MEM_Ack. Outputs: Stall_F/D/E/M=1, Flush_W=1. Next state MEM_WAIT, wait_cnt←1.
  2. Mispredict. Condition: Mispredict_E. Outputs: Flush_D=1, Flush_E=1, no stalls. Overrides load-use, because the dependent instruction is discarded.
  3. Load-use. Condition: Result_Src_Sel_E==RESULT_MEM && RD_E!=0 && (RD_E==RS1_D || RD_E==RS2_D). Outputs: Stall_F=1, Stall_D=1, Flush_E=1.
  4. Otherwise all stalls and flushes are 0.
- **MEM_WAIT:**
  - Stall_F/D/E/M=1 and Flush_W=1 every cycle.
  - When MEM_Ack=1: return to RUN. Stalls drop the same cycle, so the instruction advances.
  - When wait_cnt==MEM_TIMEOUT-1 and still no ack: Mem_Fault=1 for the next cycle, return to RUN, release stalls. The exception path is outside this block.
  - Mispredict_E and load-use are not acted on in MEM_WAIT. They are held stable by Stall_E/Stall_D and resolved in RUN.
- **Forwarding (all states):** for operand A, using RS1_E:
  - 2'b10 if REG_W_En_M && RD_M!=0 && RD_M==RS1_E;
  - else 2'b01 if REG_W_En_W && RD_W!=0 && RD_W==RS1_E;
  - else 2'b00.
  - Operand B is identical using RS2_E. Memory stage has priority over Writeback.
- **Counters:**
  - Stall_Count increments on every cycle with Stall_F=1 in RUN or MEM_WAIT.
  - Flush_Count increments on every RUN cycle with Mispredict_E=1.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- Stall, flush and forward outputs are combinational from the state and current inputs, so they act at the next rising edge.
- Mem_Fault, the counters and the FSM state are registered.
- Cycle after RST high: state INIT; Flush_D/E/W=1, Stall_F=1, Stall_D/E/M=0, Forward=00, Mem_Fault=0, counters=0.
- First RUN cycle is exactly INIT_CYCLES cycles after the reset is released.
- A load-use costs exactly one bubble.
- A mispredict costs exactly two squashed instructions.
- RST asserted in MEM_WAIT: the next state is INIT and no Mem_Fault is produced.
- MEM_Ack together with Mispredict_E in the same RUN cycle: no memory wait, the mispredict flush applies.

## Structure
- Add to definitions package:
  - RESULT_MEM encoding;
  - hazard_state_t enum {INIT, RUN, MEM_WAIT};
  - FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- Sub-module forwarding_unit: purely combinational, instantiated twice (operands A and B).

## Test plan
- **Reset fill:** RST for 1 cycle, INIT_CYCLES=3 → Flush_D/E/W=1 and Stall_F=1 for exactly 3 cycles, then all 0.
- **Load-use:** Result_Src_Sel_E=RESULT_MEM, RD_E=5, RS1_D=5 → one cycle with Stall_F=Stall_D=Flush_E=1; Stall_Count=1.
- **Mispredict over load-use:** Mispredict_E=1 plus the load-use condition → Flush_D=Flush_E=1, Stall_F=0; Flush_Count=1.
- **Memory wait:** MEM_Req_M=1, MEM_Ack low for 4 cycles then high → Stall_F/D/E/M=1 for 4 cycles and 0 on the ack cycle.
- **Timeout:** MEM_TIMEOUT=8, no ack → Mem_Fault pulses for 1 cycle after 8 stalled cycles, FSM returns to RUN.
- **Forwarding:** RD_M=RD_W=7 with both write enables set, RS1_E=7, RS2_E=0 → Forward_A_E=10, Forward_B_E=00.
